// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared register-file constants and index type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;
    localparam int REGIDX_WIDTH  = 5;
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef logic [REGIDX_WIDTH-1:0] regidx_t;
endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module      : regfile_mp_if
// Description : Decode/writeback bundle of the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if
    import rv32i_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   i_rd_addr;
    logic [NRD-1:0][XLEN-1:0] o_rd_data;
    logic [NRD-1:0]           o_rd_busy;
    logic [NWR-1:0]           i_wr_en;
    logic [NWR-1:0][AW-1:0]   i_wr_addr;
    logic [NWR-1:0][XLEN-1:0] i_wr_data;
    logic                     i_rsv_en;
    logic [AW-1:0]            i_rsv_addr;
    logic                     i_flush;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        output i_rsv_en, i_rsv_addr, i_flush,
        input  o_rd_data, o_rd_busy
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        input  i_rsv_en, i_rsv_addr, i_flush,
        output o_rd_data, o_rd_busy
    );
endinterface

`default_nettype wire

// File: rtl/regfile_wr_arb.sv
// ============================================================================
// Module      : regfile_wr_arb
// Description : Per-register write arbiter; highest-numbered matching port wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arb
    import rv32i_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int AW      = REGIDX_WIDTH,
    parameter int NWR     = 1,
    parameter int REG_IDX = 1
) (
    input  wire logic [NWR-1:0]           i_wr_en,
    input  wire logic [NWR-1:0][AW-1:0]   i_wr_addr,
    input  wire logic [NWR-1:0][XLEN-1:0] i_wr_data,
    output logic                          o_hit,
    output logic [XLEN-1:0]               o_data
);
    localparam logic [AW-1:0] C_IDX = AW'(REG_IDX);

    // Ascending scan: a later (higher) port overrides an earlier match.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int p = 0; p < NWR; p++) begin
            if (i_wr_en[p] && (i_wr_addr[p] == C_IDX)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data[p];
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file with per-register busy scoreboard.
//               Optional write-through bypass under macro REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import rv32i_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst_n,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic [NREGS-1:0]           wr_hit;
    logic [NREGS-1:0][XLEN-1:0] wr_sel;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign wr_hit[r] = 1'b0;
            assign wr_sel[r] = '0;
        end else begin : g_arb
            regfile_wr_arb #(
                .XLEN    (XLEN),
                .AW      (AW),
                .NWR     (NWR),
                .REG_IDX (r)
            ) u_arb (
                .i_wr_en   (bus.i_wr_en),
                .i_wr_addr (bus.i_wr_addr),
                .i_wr_data (bus.i_wr_data),
                .o_hit     (wr_hit[r]),
                .o_data    (wr_sel[r])
            );
        end
    end

    // Busy priority: flush, then reserve (younger instruction), then write-clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if (wr_hit[r]) begin
                regs_d[r] = wr_sel[r];
            end
            if (bus.i_flush) begin
                busy_d[r] = 1'b0;
            end else if (bus.i_rsv_en && (bus.i_rsv_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        bus.o_rd_data = '0;
        bus.o_rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
`ifdef REGFILE_BYPASS_EN
            // wr_hit[0] is tied low, so x0 never bypasses.
            if (wr_hit[bus.i_rd_addr[p]]) begin
                bus.o_rd_data[p] = wr_sel[bus.i_rd_addr[p]];
                bus.o_rd_busy[p] = 1'b0;
            end else begin
                bus.o_rd_data[p] = regs_q[bus.i_rd_addr[p]];
                bus.o_rd_busy[p] = busy_q[bus.i_rd_addr[p]];
            end
`else
            bus.o_rd_data[p] = regs_q[bus.i_rd_addr[p]];
            bus.o_rd_busy[p] = busy_q[bus.i_rd_addr[p]];
`endif
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed plus randomized bench for regfile_mp (NWR=2, NRD=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_on = 1'b0;

    logic [XLEN-1:0] m_mem  [NREGS];
    logic            m_busy [NREGS];

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=%h req=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: which port (if any) writes register a this cycle; highest wins.
    function automatic int win_port(input int a);
        int w = -1;
        for (int p = 0; p < NWR; p++)
            if (bus.i_wr_en[p] && int'(bus.i_wr_addr[p]) == a && a != 0) w = p;
        return w;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (win_port(a) >= 0) return bus.i_wr_data[win_port(a)];
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (win_port(a) >= 0) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                int w;
                w = win_port(r);
                if (w >= 0) m_mem[r] = bus.i_wr_data[w];
                if (bus.i_flush) m_busy[r] = 1'b0;
                else if (bus.i_rsv_en && int'(bus.i_rsv_addr) == r) m_busy[r] = 1'b1;
                else if (w >= 0) m_busy[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("cmp_data%0d", p), bus.o_rd_data[p], exp_data(int'(bus.i_rd_addr[p])));
                check($sformatf("cmp_busy%0d", p), XLEN'(bus.o_rd_busy[p]), XLEN'(exp_busy(int'(bus.i_rd_addr[p]))));
            end
        end
    end

    task automatic idle();
        bus.i_rd_addr  = '0;
        bus.i_wr_en    = '0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        bus.i_rsv_en   = 1'b0;
        bus.i_rsv_addr = '0;
        bus.i_flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        #3;
        check("reset_data", bus.o_rd_data[0], 32'h0);
        check("reset_busy", XLEN'(bus.o_rd_busy[1]), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // x0 write/reserve ignored; seed x4 for the flush check.
        step();
        bus.i_wr_en = 2'b11;
        bus.i_wr_addr[0] = 5'd0; bus.i_wr_data[0] = 32'hFFFF_FFFF;
        bus.i_wr_addr[1] = 5'd4; bus.i_wr_data[1] = 32'h0000_0044;
        bus.i_rsv_en = 1'b1; bus.i_rsv_addr = 5'd0;
        step();
        #2;
        check("x0_data", bus.o_rd_data[0], 32'h0);
        check("x0_busy", XLEN'(bus.o_rd_busy[0]), 32'h0);

        // Same-address conflict: port 1 wins.
        bus.i_wr_en = 2'b11;
        bus.i_wr_addr[0] = 5'd3; bus.i_wr_data[0] = 32'h11;
        bus.i_wr_addr[1] = 5'd3; bus.i_wr_data[1] = 32'h22;
        step();
        bus.i_rd_addr[0] = 5'd3;
        #2;
        check("conflict_x3", bus.o_rd_data[0], 32'h22);

        // Bypass: x7 old=0x55, new=0x1234.
        bus.i_wr_en = 2'b01; bus.i_wr_addr[0] = 5'd7; bus.i_wr_data[0] = 32'h55;
        step();
        bus.i_wr_en = 2'b01; bus.i_wr_addr[0] = 5'd7; bus.i_wr_data[0] = 32'h1234;
        bus.i_rd_addr[1] = 5'd7;
        #2;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same", bus.o_rd_data[1], 32'h1234);
`else
        check("bypass_same", bus.o_rd_data[1], 32'h55);
`endif
        step();
        bus.i_rd_addr[1] = 5'd7;
        #2;
        check("bypass_next", bus.o_rd_data[1], 32'h1234);

        // Scoreboard sequence on x9.
        bus.i_rsv_en = 1'b1; bus.i_rsv_addr = 5'd9;
        step();
        bus.i_rd_addr[0] = 5'd9;
        #2;
        check("sb_busy_c1", XLEN'(bus.o_rd_busy[0]), 32'h1);
        step();
        bus.i_rd_addr[0] = 5'd9;
        step();
        bus.i_rd_addr[0] = 5'd9;
        bus.i_wr_en = 2'b01; bus.i_wr_addr[0] = 5'd9; bus.i_wr_data[0] = 32'h99;
        #2;
`ifdef REGFILE_BYPASS_EN
        check("sb_busy_c3", XLEN'(bus.o_rd_busy[0]), 32'h0);
`else
        check("sb_busy_c3", XLEN'(bus.o_rd_busy[0]), 32'h1);
`endif
        step();
        bus.i_rd_addr[0] = 5'd9;
        #2;
        check("sb_busy_c4", XLEN'(bus.o_rd_busy[0]), 32'h0);
        check("sb_data_c4", bus.o_rd_data[0], 32'h99);
        bus.i_rsv_en = 1'b1; bus.i_rsv_addr = 5'd9;
        bus.i_wr_en = 2'b10; bus.i_wr_addr[1] = 5'd9; bus.i_wr_data[1] = 32'hABCD;
        step();
        bus.i_rd_addr[0] = 5'd9;
        #2;
        check("rsv_wr_busy", XLEN'(bus.o_rd_busy[0]), 32'h1);
        check("rsv_wr_data", bus.o_rd_data[0], 32'hABCD);

        // Flush clears everything including a same-cycle reserve.
        bus.i_rsv_en = 1'b1; bus.i_rsv_addr = 5'd4;
        step();
        bus.i_rsv_en = 1'b1; bus.i_rsv_addr = 5'd8;
        bus.i_rd_addr[0] = 5'd4;
        #2;
        check("pre_flush_x4", XLEN'(bus.o_rd_busy[0]), 32'h1);
        step();
        bus.i_flush = 1'b1; bus.i_rsv_en = 1'b1; bus.i_rsv_addr = 5'd10;
        bus.i_rd_addr[0] = 5'd8;
        #2;
        check("pre_flush_x8", XLEN'(bus.o_rd_busy[0]), 32'h1);
        step();
        bus.i_rd_addr[0] = 5'd4; bus.i_rd_addr[1] = 5'd10;
        #2;
        check("flush_x4_busy", XLEN'(bus.o_rd_busy[0]), 32'h0);
        check("flush_x10_busy", XLEN'(bus.o_rd_busy[1]), 32'h0);
        check("flush_x4_data", bus.o_rd_data[0], 32'h44);
        step();
        bus.i_rd_addr[0] = 5'd8; bus.i_rd_addr[1] = 5'd9;
        #2;
        check("flush_x8_busy", XLEN'(bus.o_rd_busy[0]), 32'h0);
        check("flush_x9_busy", XLEN'(bus.o_rd_busy[1]), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step();
            for (int p = 0; p < NRD; p++) bus.i_rd_addr[p] = 5'($urandom_range(0, 31));
            for (int p = 0; p < NWR; p++) begin
                bus.i_wr_en[p]   = 1'($urandom_range(0, 1));
                bus.i_wr_addr[p] = 5'($urandom_range(0, 31));
                bus.i_wr_data[p] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) bus.i_wr_addr[1] = bus.i_wr_addr[0];
            if ($urandom_range(0, 3) == 0) bus.i_rd_addr[0] = bus.i_wr_addr[1];
            bus.i_rsv_en   = ($urandom_range(0, 9) < 3);
            bus.i_rsv_addr = ($urandom_range(0, 3) == 0) ? bus.i_wr_addr[0] : 5'($urandom_range(0, 31));
            bus.i_flush    = ($urandom_range(0, 19) == 0);
        end

        // Asynchronous reset mid-run.
        step();
        bus.i_wr_en = 2'b01; bus.i_wr_addr[0] = 5'd5; bus.i_wr_data[0] = 32'hDEAD_BEEF;
        step();
        bus.i_rd_addr[0] = 5'd5;
        #2;
        check("pre_reset_x5", bus.o_rd_data[0], 32'hDEAD_BEEF);
        bus.i_wr_en = 2'b01; bus.i_wr_addr[0] = 5'd6; bus.i_wr_data[0] = 32'h66;
        bus.i_rsv_en = 1'b1; bus.i_rsv_addr = 5'd5;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", bus.o_rd_data[0], 32'h0);
        check("async_rst_busy", XLEN'(bus.o_rd_busy[0]), 32'h0);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.i_rd_addr[0] = 5'd6; bus.i_rd_addr[1] = 5'd5;
        #2;
        check("rst_drop_wr", bus.o_rd_data[0], 32'h0);
        check("rst_drop_rsv", XLEN'(bus.o_rd_busy[1]), 32'h0);
        step();
        step();
        cmp_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
